// File: rtl/ram_arb3.sv
// ram_arb3: three-master Wishbone arbiter for a single-port RAM (A priority, B/C round-robin, starvation limit, watchdog)
module ram_arb3 #(
  parameter int WIDTH   = 32,
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             a_cyc,
  input  logic             a_we,
  input  logic [3:0]       a_sel,
  input  logic [WIDTH-1:0] a_adr,
  input  logic [WIDTH-1:0] a_dat,
  output logic             a_ack,
  output logic [WIDTH-1:0] a_rdt,
  input  logic             b_cyc,
  input  logic             b_we,
  input  logic [3:0]       b_sel,
  input  logic [WIDTH-1:0] b_adr,
  input  logic [WIDTH-1:0] b_dat,
  output logic             b_ack,
  output logic [WIDTH-1:0] b_rdt,
  input  logic             c_cyc,
  input  logic             c_we,
  input  logic [3:0]       c_sel,
  input  logic [WIDTH-1:0] c_adr,
  input  logic [WIDTH-1:0] c_dat,
  output logic             c_ack,
  output logic [WIDTH-1:0] c_rdt,
  output logic             x_cyc,
  output logic             x_we,
  output logic [3:0]       x_sel,
  output logic [WIDTH-1:0] x_adr,
  output logic [WIDTH-1:0] x_dat,
  input  logic             x_ack,
  input  logic [WIDTH-1:0] x_rdt,
  output logic [1:0]       owner,
  output logic             timeout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  logic [1:0] state, win, rr;
  logic       rr_last, dma, pick_b, o_cyc, busy, a_hit, b_hit, c_hit;
  logic [3:0] starve;
  logic [7:0] wdog;
  logic [2:0] to_ack;
  always_comb begin
    dma    = b_cyc | c_cyc;
    pick_b = b_cyc & (rr_last | ~c_cyc);
    rr     = pick_b ? 2'd2 : 2'd3;
    win    = (starve == 4'(STARVE) && dma) ? rr : a_cyc ? 2'd1 : dma ? rr : 2'd0;
    busy   = state == BUSY;
    o_cyc  = owner == 2'd1 ? a_cyc : owner == 2'd2 ? b_cyc : owner == 2'd3 ? c_cyc : 1'b0;
    x_cyc  = busy & o_cyc;
    x_we   = owner == 2'd1 ? a_we  : owner == 2'd2 ? b_we  : owner == 2'd3 ? c_we  : 1'b0;
    x_sel  = owner == 2'd1 ? a_sel : owner == 2'd2 ? b_sel : owner == 2'd3 ? c_sel : 4'd0;
    x_adr  = owner == 2'd1 ? a_adr : owner == 2'd2 ? b_adr : owner == 2'd3 ? c_adr : '0;
    x_dat  = owner == 2'd1 ? a_dat : owner == 2'd2 ? b_dat : owner == 2'd3 ? c_dat : '0;
    a_hit  = busy & x_ack & (owner == 2'd1);
    b_hit  = busy & x_ack & (owner == 2'd2);
    c_hit  = busy & x_ack & (owner == 2'd3);
    // watchdog acks are registered and carry no data
    a_ack  = a_hit | to_ack[0];
    b_ack  = b_hit | to_ack[1];
    c_ack  = c_hit | to_ack[2];
    a_rdt  = a_hit ? x_rdt : '0;
    b_rdt  = b_hit ? x_rdt : '0;
    c_rdt  = c_hit ? x_rdt : '0;
  end
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      owner   <= 2'd0;
      rr_last <= 1'b1;
      starve  <= 4'd0;
      wdog    <= 8'd0;
      to_ack  <= 3'd0;
      timeout <= 1'b0;
    end else begin
      to_ack  <= 3'd0;
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (win != 2'd0) begin
          state <= BUSY;
          owner <= win;
          wdog  <= 8'd0;
          if (win == 2'd1) begin
            starve <= !dma ? 4'd0 : starve == 4'(STARVE) ? starve : starve + 4'd1;
          end else begin
            starve  <= 4'd0;
            rr_last <= win == 2'd3;
          end
        end
      end else if (state == BUSY) begin
        if (x_ack || !o_cyc) begin
          state <= GAP;
          owner <= 2'd0;
        end else if (wdog == 8'(TIMEOUT)) begin
          state   <= GAP;
          owner   <= 2'd0;
          timeout <= 1'b1;
          to_ack  <= {owner == 2'd3, owner == 2'd2, owner == 2'd1};
        end else begin
          wdog <= wdog + 8'd1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ram_arb3.sv
// tb_ram_arb3: scoreboard bench for ram_arb3 with queue-driven masters and a 1-cycle-ack RAM model
module tb_ram_arb3;
  localparam int TO = 15;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
  typedef struct {logic [1:0] port; logic [31:0] rdt; logic to; logic [1:0] own; int lat;} exp_t;
  logic wb_clk = 0, wb_rst = 1;
  logic a_cyc = 0, a_we = 0, b_cyc = 0, b_we = 0, c_cyc = 0, c_we = 0;
  logic [3:0] a_sel = 0, b_sel = 0, c_sel = 0;
  logic [31:0] a_adr = 0, a_dat = 0, b_adr = 0, b_dat = 0, c_adr = 0, c_dat = 0;
  logic a_ack, b_ack, c_ack, x_cyc, x_we, timeout;
  logic [31:0] a_rdt, b_rdt, c_rdt, x_adr, x_dat;
  logic [3:0] x_sel;
  logic [1:0] owner;
  logic x_ack;
  logic [31:0] x_rdt;
  txn_t qa[$], qb[$], qc[$];
  exp_t eq[$];
  logic [31:0] mem [logic [31:0]];
  int tests = 0, fails = 0, cyc_n = 0, last_rise = 0;
  logic prev_x = 0;

  ram_arb3 #(.WIDTH(32), .STARVE(4), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .a_cyc(a_cyc), .a_we(a_we), .a_sel(a_sel), .a_adr(a_adr), .a_dat(a_dat), .a_ack(a_ack), .a_rdt(a_rdt),
    .b_cyc(b_cyc), .b_we(b_we), .b_sel(b_sel), .b_adr(b_adr), .b_dat(b_dat), .b_ack(b_ack), .b_rdt(b_rdt),
    .c_cyc(c_cyc), .c_we(c_we), .c_sel(c_sel), .c_adr(c_adr), .c_dat(c_dat), .c_ack(c_ack), .c_rdt(c_rdt),
    .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat), .x_ack(x_ack), .x_rdt(x_rdt),
    .owner(owner), .timeout(timeout)
  );

  always #5 wb_clk = ~wb_clk;

  // RAM model: acks one cycle after x_cyc; addresses 0xF... never ack
  always @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      x_ack <= 0;
      x_rdt <= 0;
    end else begin
      x_ack <= 0;
      x_rdt <= 0;
      if (x_cyc && !x_ack && x_adr[31:28] != 4'hF) begin
        x_ack <= 1;
        if (x_we) mem[x_adr] = x_dat;
        else x_rdt <= mem.exists(x_adr) ? mem[x_adr] : 32'h0;
      end
    end
  end

  // masters: hold cyc with the head transaction until acked
  always @(negedge wb_clk) begin
    if (a_ack && qa.size() > 0) void'(qa.pop_front());
    if (b_ack && qb.size() > 0) void'(qb.pop_front());
    if (c_ack && qc.size() > 0) void'(qc.pop_front());
    a_cyc = qa.size() > 0; a_sel = {4{a_cyc}};
    b_cyc = qb.size() > 0; b_sel = {4{b_cyc}};
    c_cyc = qc.size() > 0; c_sel = {4{c_cyc}};
    {a_we, a_adr, a_dat} = a_cyc ? {qa[0].we, qa[0].adr, qa[0].dat} : 65'h0;
    {b_we, b_adr, b_dat} = b_cyc ? {qb[0].we, qb[0].adr, qb[0].dat} : 65'h0;
    {c_we, c_adr, c_dat} = c_cyc ? {qc[0].we, qc[0].adr, qc[0].dat} : 65'h0;
  end

  // monitor: every ack pops one expected response
  always @(negedge wb_clk) begin
    int n;
    logic [1:0] p;
    logic [31:0] r, oth;
    exp_t e;
    cyc_n++;
    if (x_cyc && !prev_x) last_rise = cyc_n;
    prev_x = x_cyc;
    n = int'(a_ack) + int'(b_ack) + int'(c_ack);
    if (n != 0) begin
      p   = a_ack ? 2'd1 : b_ack ? 2'd2 : 2'd3;
      r   = a_ack ? a_rdt : b_ack ? b_rdt : c_rdt;
      oth = (a_ack ? 32'h0 : a_rdt) | (b_ack ? 32'h0 : b_rdt) | (c_ack ? 32'h0 : c_rdt);
      tests++;
      if (eq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: port=%0d rdt=%h, no response expected", p, r);
      end else begin
        e = eq.pop_front();
        if (n != 1 || p != e.port || r != e.rdt || timeout != e.to || owner != e.own || oth != 0 || cyc_n - last_rise != e.lat) begin
          fails++;
          $display("FAIL ack: got n=%0d port=%0d rdt=%h to=%b own=%0d oth=%h lat=%0d, want n=1 port=%0d rdt=%h to=%b own=%0d oth=0 lat=%0d",
                   n, p, r, timeout, owner, oth, cyc_n - last_rise, e.port, e.rdt, e.to, e.own, e.lat);
        end
      end
    end else if (timeout || (a_rdt | b_rdt | c_rdt) != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_outputs: timeout=%b rdt_or=%h, want 0 without an ack", timeout, a_rdt | b_rdt | c_rdt);
    end
  end

  function automatic txn_t rd(logic [31:0] a);
    txn_t t;
    t.we = 0; t.adr = a; t.dat = 0;
    return t;
  endfunction
  function automatic txn_t wr(logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.we = 1; t.adr = a; t.dat = d;
    return t;
  endfunction
  function automatic exp_t ex(logic [1:0] p, logic [31:0] r, logic to, int lat);
    exp_t e;
    e.port = p; e.rdt = r; e.to = to; e.own = to ? 2'd0 : p; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic do_reset();
    wb_rst = 1;
    qa.delete(); qb.delete(); qc.delete(); eq.delete();
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i = 0;
    while (i < budget && qa.size() + qb.size() + qc.size() + eq.size() != 0) begin
      @(negedge wb_clk);
      i++;
    end
    chk({nm, "_drain"}, 64'(qa.size() + qb.size() + qc.size() + eq.size()), 64'd0);
    repeat (3) @(negedge wb_clk);
  endtask

  task automatic wait_owner(input logic [1:0] want);
    int i = 0;
    while (i < 20 && owner != want) begin
      @(negedge wb_clk);
      i++;
    end
    chk("owner_wait", 64'(owner), 64'(want));
  endtask

  initial begin
    mem[32'h100] = 32'hAAAA_0001;
    mem[32'h200] = 32'hBBBB_0002;
    mem[32'h300] = 32'hCCCC_0003;
    repeat (2) @(negedge wb_clk);
    chk("reset_ctl", 64'({owner, x_cyc, x_we, x_sel, timeout, a_ack, b_ack, c_ack}), 64'd0);
    chk("reset_bus", 64'(x_adr | x_dat | a_rdt | b_rdt | c_rdt), 64'd0);
    wb_rst = 0;
    // CPU write then read back
    qa.push_back(wr(32'h10, 32'hDEAD_BEEF));
    qa.push_back(rd(32'h10));
    eq.push_back(ex(2'd1, 32'h0, 1'b0, 1));
    eq.push_back(ex(2'd1, 32'hDEAD_BEEF, 1'b0, 1));
    wait_done("a_only", 50);
    // simultaneous A, B, C from reset
    do_reset();
    qa.push_back(rd(32'h100)); qb.push_back(rd(32'h200)); qc.push_back(rd(32'h300));
    eq.push_back(ex(2'd1, 32'hAAAA_0001, 1'b0, 1));
    eq.push_back(ex(2'd2, 32'hBBBB_0002, 1'b0, 1));
    eq.push_back(ex(2'd3, 32'hCCCC_0003, 1'b0, 1));
    wait_done("tie3", 60);
    // starvation: A continuous with B pending
    do_reset();
    for (int i = 0; i < 6; i++) qa.push_back(rd(32'h100));
    for (int i = 0; i < 2; i++) qb.push_back(rd(32'h200));
    for (int i = 0; i < 8; i++)
      eq.push_back((i == 4 || i == 7) ? ex(2'd2, 32'hBBBB_0002, 1'b0, 1) : ex(2'd1, 32'hAAAA_0001, 1'b0, 1));
    wait_done("starve", 100);
    // B and C round-robin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      qb.push_back(rd(32'h200));
      qc.push_back(rd(32'h300));
      eq.push_back(ex(2'd2, 32'hBBBB_0002, 1'b0, 1));
      eq.push_back(ex(2'd3, 32'hCCCC_0003, 1'b0, 1));
    end
    wait_done("rr", 100);
    // watchdog on C, then pending B proceeds
    do_reset();
    qc.push_back(rd(32'hF000_0000));
    eq.push_back(ex(2'd3, 32'h0, 1'b1, TO + 1));
    wait_owner(2'd3);
    qb.push_back(rd(32'h200));
    eq.push_back(ex(2'd2, 32'hBBBB_0002, 1'b0, 1));
    wait_done("watchdog", 100);
    // async reset while B is in BUSY
    do_reset();
    qb.push_back(rd(32'hF000_0000));
    wait_owner(2'd2);
    @(posedge wb_clk);
    #1 chk("pre_rst_xcyc", 64'(x_cyc), 64'd1);
    #1 wb_rst = 1;
    #1 chk("async_drop", 64'({x_cyc, b_ack, owner}), 64'd0);
    qb.delete(); eq.delete();
    repeat (2) @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 0;
    chk("post_rst", 64'({owner, x_cyc, timeout}), 64'd0);
    qb.push_back(rd(32'h200)); qc.push_back(rd(32'h300));
    eq.push_back(ex(2'd2, 32'hBBBB_0002, 1'b0, 1));
    eq.push_back(ex(2'd3, 32'hCCCC_0003, 1'b0, 1));
    wait_done("post_rst_tie", 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
